carry_select_adder_pipe: RTL and testbench

//  Parametrised, two-stage pipelined carry-select adder/subtractor.

---
 rtl/carry_select_adder_pipe.sv | 157 +++++++++++++++
 tb/tb_carry_select_adder_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready streaming.
// Stage 1 precomputes each group's sum and carry for both possible carry-ins.
// Stage 2 resolves the true carries through a select chain and registers the
// result. Both stages move together whenever the output slot is free or drained.
`timescale 1ns/1ps

module carry_select_adder_pipe #(
  parameter int WIDTH = 16,  // operand/result width, multiple of BLOCK
  parameter int BLOCK = 2    // bits per carry-select group, WIDTH/BLOCK >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // One group's add with an explicit carry-in; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] grp_add(input logic [BLOCK-1:0] x,
                                             input logic [BLOCK-1:0] y,
                                             input logic             ci);
    grp_add = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, ci};
  endfunction

  // Signed overflow: operands of equal sign whose result sign differs.
  function automatic logic ovf_detect(input logic a_msb,
                                      input logic bb_msb,
                                      input logic s_msb);
    logic signed [1:0] sa;
    logic signed [1:0] sbb;
    sa  = {a_msb, 1'b0};
    sbb = {bb_msb, 1'b0};
    ovf_detect = (sa == sbb) && (s_msb != a_msb);
  endfunction

  // Effective operands: subtraction is a + ~b + 1, so cin is ignored in sub mode.
  logic [WIDTH-1:0] bb;
  logic             c0;

  assign bb = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;

  // Both stages advance together whenever the output slot can take new data.
  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: per-group precompute for carry-in 0 and 1
  // ---------------------------------------------------------------------------
  // Group 0 sees the real carry-in immediately, so only its c0 result exists;
  // c0 itself is folded into that result and needs no separate register.
  logic [BLOCK-1:0]             g0_s_d;
  logic                         g0_k_d;
  logic [NBLK-1:1][BLOCK-1:0]   s0_d;
  logic [NBLK-1:1][BLOCK-1:0]   s1_d;
  logic [NBLK-1:1]              k0_d;
  logic [NBLK-1:1]              k1_d;

  // Speculative group sums for both carry-in values.
  always_comb begin
    g0_s_d = '0;
    g0_k_d = 1'b0;
    s0_d   = '0;
    s1_d   = '0;
    k0_d   = '0;
    k1_d   = '0;
    {g0_k_d, g0_s_d} = grp_add(a[BLOCK-1:0], bb[BLOCK-1:0], c0);
    for (int g = 1; g < NBLK; g++) begin
      {k0_d[g], s0_d[g]} = grp_add(a[g*BLOCK +: BLOCK], bb[g*BLOCK +: BLOCK], 1'b0);
      {k1_d[g], s1_d[g]} = grp_add(a[g*BLOCK +: BLOCK], bb[g*BLOCK +: BLOCK], 1'b1);
    end
  end

  logic                         vld_p1;
  logic [BLOCK-1:0]             g0_s_p1;
  logic                         g0_k_p1;
  logic [NBLK-1:1][BLOCK-1:0]   s0_p1;
  logic [NBLK-1:1][BLOCK-1:0]   s1_p1;
  logic [NBLK-1:1]              k0_p1;
  logic [NBLK-1:1]              k1_p1;
  logic                         a_msb_p1;
  logic                         bb_msb_p1;

  // Stage 1 register: captures the offered beat (or a bubble) on every advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      g0_s_p1   <= '0;
      g0_k_p1   <= 1'b0;
      s0_p1     <= '0;
      s1_p1     <= '0;
      k0_p1     <= '0;
      k1_p1     <= '0;
      a_msb_p1  <= 1'b0;
      bb_msb_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      g0_s_p1   <= g0_s_d;
      g0_k_p1   <= g0_k_d;
      s0_p1     <= s0_d;
      s1_p1     <= s1_d;
      k0_p1     <= k0_d;
      k1_p1     <= k1_d;
      a_msb_p1  <= a[WIDTH-1];
      bb_msb_p1 <= bb[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: carry select chain and result register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Walk the groups LSB to MSB, picking each group's precomputed pair by the
  // carry resolved so far.
  always_comb begin : carry_select
    logic c;
    sum_d  = '0;
    cout_d = 1'b0;
    c      = g0_k_p1;
    sum_d[BLOCK-1:0] = g0_s_p1;
    for (int g = 1; g < NBLK; g++) begin
      sum_d[g*BLOCK +: BLOCK] = c ? s1_p1[g] : s0_p1[g];
      c = c ? k1_p1[g] : k0_p1[g];
    end
    cout_d = c;
  end

  // Output register: holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p1;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_detect(a_msb_p1, bb_msb_p1, sum_d[WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Testbench for carry_select_adder_pipe: four instances (BLOCK = 1, 2, 4, 8)
// share one stimulus stream and are checked against an arithmetic reference.
`timescale 1ns/1ps

module tb_carry_select_adder_pipe;

  localparam int WIDTH = 16;
  localparam int NDUT  = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             cin;
  logic             sub;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [NDUT-1:0]  in_ready;
  logic [NDUT-1:0]  out_valid;
  logic [NDUT-1:0]  cout;
  logic [NDUT-1:0]  ovf;
  logic [WIDTH-1:0] sum [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    carry_select_adder_pipe #(.WIDTH(WIDTH), .BLOCK(1 << i)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready[i]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid[i]),
      .out_ready(out_ready),
      .sum      (sum[i]),
      .cout     (cout[i]),
      .ovf      (ovf[i])
    );
  end

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic ci, input logic sb);
    res_t   r;
    longint ux, uy, sx, sy, ufull, sfull;
    longint smax, smin;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (sb) begin
      ufull  = ux - uy;
      sfull  = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      ufull  = ux + uy + longint'(ci);
      sfull  = sx + sy + longint'(ci);
      r.cout = (ufull >= (longint'(1) <<< WIDTH));
    end
    r.sum = ufull[WIDTH-1:0];
    r.ovf = (sfull > smax) || (sfull < smin);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vc, input logic vs);
    in_valid = v;
    a        = va;
    b        = vb;
    cin      = vc;
    sub      = vs;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0 || sum[k] !== '0 || cout[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: valid=%b sum=%h cout=%b ovf=%b, required 0/0000/0/0",
                 k, out_valid[k], sum[k], cout[k], ovf[k]);
      end
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d: got %b required 1", k, in_ready[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One isolated beat; checks acceptance, 2-edge latency and the result.
  task automatic test_single(input string name, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb, input logic vc, input logic vs,
                             input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    out_ready = 1'b1;
    drive(1'b1, va, vb, vc, vs);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_in_ready dut%0d: got %b required 1", name, k, in_ready[k]);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early_valid dut%0d: got %b required 0", name, k, out_valid[k]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b1 || sum[k] !== es || cout[k] !== ec || ovf[k] !== eo) begin
        n_fail++;
        $display("FAIL %s_result dut%0d: valid=%b sum=%h cout=%b ovf=%b, required 1/%h/%b/%b",
                 name, k, out_valid[k], sum[k], cout[k], ovf[k], es, ec, eo);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    test_single("add_ff_1",     16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    test_single("ripple_all",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_single("pos_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_single("neg_ovf",      16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    test_single("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_single("sub_cin_ign",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    test_single("add_cin",      16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
  endtask

  // Four back-to-back beats against a consumer that stalls for cycles 0-4.
  task automatic test_back_to_back_stall();
    int idx = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 5);
      drive(idx < 4, 16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        n_checks++;
        if (in_ready[k] !== !(c >= 2 && c < 5)) begin
          n_fail++;
          $display("FAIL stall_in_ready c%0d dut%0d: got %b required %b",
                   c, k, in_ready[k], !(c >= 2 && c < 5));
        end
        if (out_valid[k]) begin
          n_checks++;
          if (sum[k] !== 16'(2 * (got + 1)) || cout[k] !== 1'b0 || ovf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_data c%0d dut%0d: sum=%h required %h", c, k, sum[k],
                     16'(2 * (got + 1)));
          end
        end
      end
      if (out_valid[0] && out_ready) got++;
      if (in_valid && in_ready[0]) idx++;
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL stall_count: drained %0d beats, required 4", got);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 16'd1, 16'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd3, 16'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b1 || sum[k] !== 16'd3) begin
        n_fail++;
        $display("FAIL pre_reset_out dut%0d: valid=%b sum=%h, required 1/0003",
                 k, out_valid[k], sum[k]);
      end
    end
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0 || sum[k] !== '0 || cout[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: valid=%b sum=%h cout=%b ovf=%b, required 0/0000/0/0",
                 k, out_valid[k], sum[k], cout[k], ovf[k]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL discarded_beat dut%0d: valid=%b required 0", k, out_valid[k]);
      end
    end
    @(posedge clk); #1;
    test_single("restart", 16'd9, 16'd1, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0);
  endtask

  // Random operands, bubbles and back-pressure against the reference model.
  task automatic test_random(input int ncyc);
    res_t q[$];
    res_t r;
    bit   feeding;
    for (int c = 0; c < ncyc + 30; c++) begin
      feeding = (c < ncyc);
      if (!feeding && q.size() == 0 && !out_valid[0]) break;
      drive(feeding && ($urandom_range(3) != 0), pick(), pick(),
            1'($urandom_range(1)), 1'($urandom_range(1)));
      out_ready = feeding ? ($urandom_range(9) < 7) : 1'b1;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        n_checks++;
        if (in_ready[k] !== (!out_valid[k] || out_ready)) begin
          n_fail++;
          $display("FAIL rand_in_ready c%0d dut%0d: got %b required %b", c, k, in_ready[k],
                   !out_valid[k] || out_ready);
        end
        if (out_valid[k]) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_spurious c%0d dut%0d: out_valid=1 with no beat outstanding", c, k);
          end else if (sum[k] !== q[0].sum || cout[k] !== q[0].cout || ovf[k] !== q[0].ovf) begin
            n_fail++;
            $display("FAIL rand_data c%0d dut%0d: sum=%h cout=%b ovf=%b, required %h/%b/%b",
                     c, k, sum[k], cout[k], ovf[k], q[0].sum, q[0].cout, q[0].ovf);
          end
        end
      end
      if (out_valid[0] && out_ready && q.size() > 0) r = q.pop_front();
      if (in_valid && in_ready[0]) q.push_back(ref_model(a, b, cin, sub));
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d beats never emerged, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back_stall();
    test_reset_midstream();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
